// File: rtl/regfile_pkg.sv
// Shared limits, defaults and the write-port priority helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned MAX_RD   = 4;
    localparam int unsigned MAX_WR   = 2;
    localparam int unsigned WR_SEL_W = $clog2(MAX_WR);

    localparam bit ZERO_R0_DEFAULT = 1'b1;
    localparam bit BYPASS_DEFAULT  = 1'b1;

    typedef struct packed {
        logic                hit;
        logic [WR_SEL_W-1:0] port;
    } hit_t;

    // Later ports override earlier ones, so the highest matching port is returned.
    function automatic hit_t hit_sel(input logic [MAX_WR-1:0] match);
        hit_t res;
        res = '0;
        for (int k = 0; k < MAX_WR; k++) begin
            if (match[k]) begin
                res.hit  = 1'b1;
                res.port = WR_SEL_W'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Issue/writeback-facing bundle of the multi-port register file: reads, writes and reservations.
interface regfile_mp_if #(
    parameter int unsigned N_BITS = 32,
    parameter int unsigned N_REGS = 32,
    parameter int unsigned N_RD   = 2,
    parameter int unsigned N_WR   = 1
);
    localparam int unsigned N_IDX = $clog2(N_REGS);

    logic [N_RD*N_IDX-1:0]  rd_idx;
    logic [N_RD*N_BITS-1:0] rd_data;
    logic [N_RD-1:0]        rd_busy;
    logic [N_WR-1:0]        wr_en;
    logic [N_WR*N_IDX-1:0]  wr_idx;
    logic [N_WR*N_BITS-1:0] wr_data;
    logic                   rsv_en;
    logic [N_IDX-1:0]       rsv_idx;
    logic                   all_idle;

    modport master (
        output rd_idx, wr_en, wr_idx, wr_data, rsv_en, rsv_idx,
        input  rd_data, rd_busy, all_idle
    );

    modport slave (
        input  rd_idx, wr_en, wr_idx, wr_data, rsv_en, rsv_idx,
        output rd_data, rd_busy, all_idle
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: reservations set, writebacks clear, all_idle summarises the state.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned N_REGS  = 32,
    parameter bit          ZERO_R0 = ZERO_R0_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rsv_en,
    input  logic [$clog2(N_REGS)-1:0]        rsv_idx,
    input  logic [MAX_WR-1:0]                wr_en,
    input  logic [MAX_WR*$clog2(N_REGS)-1:0] wr_idx,
    output logic [N_REGS-1:0]                busy,
    output logic                             all_idle
);
    localparam int unsigned N_IDX = $clog2(N_REGS);

    logic [N_REGS-1:0] busy_q;
    logic [N_REGS-1:0] set_vec;
    logic [N_REGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_en && !(ZERO_R0 && rsv_idx == '0)) begin
            set_vec[rsv_idx] = 1'b1;
        end
        for (int k = 0; k < MAX_WR; k++) begin
            if (wr_en[k]) begin
                clr_vec[wr_idx[k*N_IDX +: N_IDX]] = 1'b1;
            end
        end
    end

    // Set outranks clear: a same-cycle reservation belongs to a newer producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_vec) | set_vec;
        end
    end

    assign busy     = busy_q;
    assign all_idle = ~|busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional hardwired r0, write bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned N_BITS  = 32,
    parameter int unsigned N_REGS  = 32,
    parameter int unsigned N_RD    = 2,
    parameter int unsigned N_WR    = 1,
    parameter bit          ZERO_R0 = ZERO_R0_DEFAULT,
    parameter bit          BYPASS  = BYPASS_DEFAULT
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int unsigned N_IDX = $clog2(N_REGS);

    logic [MAX_WR-1:0]       wr_en;
    logic [N_IDX-1:0]        wr_idx  [MAX_WR];
    logic [N_BITS-1:0]       wr_data [MAX_WR];
    logic [MAX_WR*N_IDX-1:0] wr_idx_flat;
    logic [N_BITS-1:0]       regs    [N_REGS];
    logic [N_REGS-1:0]       busy;

    // Absent write ports are tied off so all priority logic is sized to MAX_WR.
    always_comb begin
        wr_en       = '0;
        wr_idx_flat = '0;
        for (int k = 0; k < MAX_WR; k++) begin
            wr_idx[k]  = '0;
            wr_data[k] = '0;
        end
        for (int k = 0; k < N_WR; k++) begin
            wr_en[k]                      = bus.wr_en[k];
            wr_idx[k]                     = bus.wr_idx[k*N_IDX +: N_IDX];
            wr_data[k]                    = bus.wr_data[k*N_BITS +: N_BITS];
            wr_idx_flat[k*N_IDX +: N_IDX] = wr_idx[k];
        end
    end

    for (genvar i = 0; i < N_REGS; i++) begin : g_entry
        if (ZERO_R0 && i == 0) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            logic [MAX_WR-1:0] match;
            hit_t              sel;
            logic [N_BITS-1:0] q;

            always_comb begin
                match = '0;
                for (int k = 0; k < MAX_WR; k++) begin
                    match[k] = wr_en[k] && (wr_idx[k] == N_IDX'(i));
                end
            end

            assign sel = hit_sel(match);

            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (sel.hit) begin
                    q <= wr_data[sel.port];
                end
            end

            assign regs[i] = q;
        end
    end

    for (genvar j = 0; j < N_RD; j++) begin : g_rd
        logic [N_IDX-1:0]  idx;
        logic [MAX_WR-1:0] match;
        hit_t              sel;
        logic [N_BITS-1:0] data;
        logic              busy_j;

        always_comb begin
            idx   = bus.rd_idx[j*N_IDX +: N_IDX];
            match = '0;
            for (int k = 0; k < MAX_WR; k++) begin
                match[k] = wr_en[k] && (wr_idx[k] == idx);
            end
            sel = hit_sel(match);
            if (ZERO_R0 && idx == '0) begin
                data   = '0;
                busy_j = 1'b0;
            end else if (BYPASS && sel.hit) begin
                data   = wr_data[sel.port];
                busy_j = 1'b0;
            end else begin
                data   = regs[idx];
                busy_j = busy[idx];
            end
        end

        assign bus.rd_data[j*N_BITS +: N_BITS] = data;
        assign bus.rd_busy[j]                  = busy_j;
    end

    regfile_scoreboard #(
        .N_REGS  (N_REGS),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (bus.rsv_en),
        .rsv_idx  (bus.rsv_idx),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx_flat),
        .busy     (busy),
        .all_idle (bus.all_idle)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomised checks of regfile_mp in two configurations (bypass/zero-r0 on and off).
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    int   n_tests;
    int   n_fail;

    always #5 clk = ~clk;

    regfile_mp_if #(.N_BITS(32), .N_REGS(32), .N_RD(2), .N_WR(2)) if_a ();
    regfile_mp_if #(.N_BITS(64), .N_REGS(16), .N_RD(4), .N_WR(2)) if_b ();

    regfile_mp #(
        .N_BITS(32), .N_REGS(32), .N_RD(2), .N_WR(2), .ZERO_R0(1'b1), .BYPASS(1'b1)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    regfile_mp #(
        .N_BITS(64), .N_REGS(16), .N_RD(4), .N_WR(2), .ZERO_R0(1'b0), .BYPASS(1'b0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        if_a.wr_en  = '0;
        if_a.rsv_en = 1'b0;
    endtask

    task automatic idle_b();
        if_b.wr_en  = '0;
        if_b.rsv_en = 1'b0;
    endtask

    task automatic wr_a(input int k, input logic [4:0] idx, input logic [31:0] d);
        if_a.wr_en[k]            = 1'b1;
        if_a.wr_idx[k*5 +: 5]    = idx;
        if_a.wr_data[k*32 +: 32] = d;
    endtask

    task automatic wr_b(input int k, input logic [3:0] idx, input logic [63:0] d);
        if_b.wr_en[k]            = 1'b1;
        if_b.wr_idx[k*4 +: 4]    = idx;
        if_b.wr_data[k*64 +: 64] = d;
    endtask

    task automatic rd_a(input int j, input logic [4:0] idx);
        if_a.rd_idx[j*5 +: 5] = idx;
    endtask

    task automatic rsv_a(input logic [4:0] idx);
        if_a.rsv_en  = 1'b1;
        if_a.rsv_idx = idx;
    endtask

    task automatic rsv_b(input logic [3:0] idx);
        if_b.rsv_en  = 1'b1;
        if_b.rsv_idx = idx;
    endtask

    function automatic logic [31:0] rda(input int j);
        return if_a.rd_data[j*32 +: 32];
    endfunction

    function automatic logic [63:0] rdb(input int j);
        return if_b.rd_data[j*64 +: 64];
    endfunction

    // Reference state for the randomised phase
    logic [31:0] ma_regs [32];
    logic [31:0] ma_busy;
    logic [63:0] mb_regs [16];
    logic [15:0] mb_busy;

    logic        a_wen   [2];
    logic [4:0]  a_widx  [2];
    logic [31:0] a_wdata [2];
    logic [4:0]  a_ridx  [2];
    logic        a_rsv;
    logic [4:0]  a_rsv_idx;
    logic        b_wen   [2];
    logic [3:0]  b_widx  [2];
    logic [63:0] b_wdata [2];
    logic [3:0]  b_ridx  [4];
    logic        b_rsv;
    logic [3:0]  b_rsv_idx;
    logic [31:0] ea_data;
    logic        ea_busy;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        if_a.rd_idx = '0; if_a.wr_en = '0; if_a.wr_idx = '0; if_a.wr_data = '0;
        if_a.rsv_en = 1'b0; if_a.rsv_idx = '0;
        if_b.rd_idx = '0; if_b.wr_en = '0; if_b.wr_idx = '0; if_b.wr_data = '0;
        if_b.rsv_en = 1'b0; if_b.rsv_idx = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state on every index and port
        for (int i = 0; i < 32; i++) begin
            if_a.rd_idx = {5'(31 - i), 5'(i)};
            if_b.rd_idx = {4'(i), 4'(15 - i), 4'(i + 3), 4'(i)};
            #1;
            check($sformatf("rst_rd_a%0d", i), {rda(1), rda(0)}, 64'h0);
            check($sformatf("rst_busy_a%0d", i), 64'(if_a.rd_busy), 64'h0);
            check($sformatf("rst_idle_a%0d", i), 64'(if_a.all_idle), 64'h1);
            if (i < 16) begin
                for (int j = 0; j < 4; j++) check($sformatf("rst_rd_b%0d_%0d", i, j), rdb(j), 64'h0);
                check($sformatf("rst_busy_b%0d", i), 64'(if_b.rd_busy), 64'h0);
                check($sformatf("rst_idle_b%0d", i), 64'(if_b.all_idle), 64'h1);
            end
            tick();
        end

        // Reset overrides a same-cycle write and reservation
        rst = 1'b1;
        wr_a(0, 5'd5, 32'hDEADBEEF);
        rsv_a(5'd6);
        tick();
        rst = 1'b0;
        idle_a();
        rd_a(0, 5'd5);
        rd_a(1, 5'd6);
        #1;
        check("rst_wins_data", 64'(rda(0)), 64'h0);
        check("rst_wins_busy", 64'(if_a.rd_busy), 64'h0);
        check("rst_wins_idle", 64'(if_a.all_idle), 64'h1);
        tick();

        // Same-cycle bypass
        wr_a(0, 5'd3, 32'h1234);
        rd_a(0, 5'd3);
        #1;
        check("byp_same", 64'(rda(0)), 64'h1234);
        check("byp_other", 64'(rda(1)), 64'h0);
        tick();
        idle_a();
        #1;
        check("byp_next", 64'(rda(0)), 64'h1234);

        // Write-port collision: highest port wins
        wr_a(0, 5'd7, 32'hAAAA);
        wr_a(1, 5'd7, 32'h5555);
        rd_a(0, 5'd7);
        #1;
        check("coll_byp", 64'(rda(0)), 64'h5555);
        tick();
        idle_a();
        #1;
        check("coll_store", 64'(rda(0)), 64'h5555);
        wr_a(0, 5'd10, 32'h11);
        wr_a(1, 5'd11, 32'h22);
        rd_a(0, 5'd10);
        rd_a(1, 5'd11);
        #1;
        check("dual_byp", {rda(1), rda(0)}, {32'h22, 32'h11});
        tick();
        idle_a();
        #1;
        check("dual_store", {rda(1), rda(0)}, {32'h22, 32'h11});

        // Hardwired r0
        wr_a(0, 5'd0, 32'hFFFFFFFF);
        rsv_a(5'd0);
        rd_a(0, 5'd0);
        #1;
        check("r0_byp", 64'(rda(0)), 64'h0);
        tick();
        idle_a();
        #1;
        check("r0_data", 64'(rda(0)), 64'h0);
        check("r0_busy", 64'(if_a.rd_busy[0]), 64'h0);
        check("r0_idle", 64'(if_a.all_idle), 64'h1);

        // Scoreboard sequence on r9
        rsv_a(5'd9);
        rd_a(0, 5'd9);
        rd_a(1, 5'd9);
        #1;
        check("sb_rsv_same_busy", 64'(if_a.rd_busy), 64'h0);
        check("sb_rsv_same_idle", 64'(if_a.all_idle), 64'h1);
        tick();
        idle_a();
        #1;
        check("sb_rsv_busy", 64'(if_a.rd_busy), 64'h3);
        check("sb_rsv_idle", 64'(if_a.all_idle), 64'h0);
        wr_a(0, 5'd9, 32'h99);
        #1;
        check("sb_wr_byp_busy", 64'(if_a.rd_busy), 64'h0);
        check("sb_wr_idle_same", 64'(if_a.all_idle), 64'h0);
        check("sb_wr_byp_data", 64'(rda(0)), 64'h99);
        tick();
        idle_a();
        #1;
        check("sb_clr_idle", 64'(if_a.all_idle), 64'h1);
        check("sb_clr_busy", 64'(if_a.rd_busy), 64'h0);
        rsv_a(5'd9);
        wr_a(1, 5'd9, 32'h77);
        #1;
        check("sb_both_data", 64'(rda(0)), 64'h77);
        tick();
        idle_a();
        #1;
        check("sb_both_busy", 64'(if_a.rd_busy), 64'h3);
        check("sb_both_idle", 64'(if_a.all_idle), 64'h0);
        check("sb_both_store", 64'(rda(1)), 64'h77);
        rd_a(1, 5'd12);
        #1;
        check("sb_port_sel", 64'(if_a.rd_busy), 64'h1);
        wr_a(1, 5'd9, 32'h0);
        tick();
        idle_a();
        rsv_a(5'd12);
        tick();
        idle_a();
        #1;
        check("sb_r12_idle", 64'(if_a.all_idle), 64'h0);
        check("sb_r12_busy", 64'(if_a.rd_busy), 64'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("sb_rst_idle", 64'(if_a.all_idle), 64'h1);

        // No bypass, no hardwired r0
        if_b.rd_idx = {4'd3, 4'd3, 4'd3, 4'd3};
        wr_b(0, 4'd3, 64'h1234);
        #1;
        check("b_nobyp_same", rdb(0), 64'h0);
        tick();
        idle_b();
        #1;
        check("b_nobyp_next0", rdb(0), 64'h1234);
        check("b_nobyp_next3", rdb(3), 64'h1234);
        wr_b(1, 4'd0, 64'hFFFFFFFF);
        if_b.rd_idx = {4'd3, 4'd3, 4'd3, 4'd0};
        #1;
        check("b_r0_same", rdb(0), 64'h0);
        tick();
        idle_b();
        #1;
        check("b_r0_data", rdb(0), 64'hFFFFFFFF);
        rsv_b(4'd0);
        #1;
        check("b_rsv_same_idle", 64'(if_b.all_idle), 64'h1);
        tick();
        idle_b();
        #1;
        check("b_r0_busy", 64'(if_b.rd_busy), 64'h1);
        check("b_r0_idle", 64'(if_b.all_idle), 64'h0);
        wr_b(0, 4'd0, 64'h5);
        #1;
        check("b_clr_same_busy", 64'(if_b.rd_busy), 64'h1);
        check("b_clr_same_data", rdb(0), 64'hFFFFFFFF);
        tick();
        idle_b();
        #1;
        check("b_clr_busy", 64'(if_b.rd_busy), 64'h0);
        check("b_clr_idle", 64'(if_b.all_idle), 64'h1);
        check("b_clr_data", rdb(0), 64'h5);

        // Randomised phase against reference models
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) ma_regs[i] = '0;
        for (int i = 0; i < 16; i++) mb_regs[i] = '0;
        ma_busy = '0;
        mb_busy = '0;
        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 2; k++) begin
                a_wen[k]   = 1'($urandom_range(0, 1));
                a_widx[k]  = 5'($urandom_range(0, 7));
                a_wdata[k] = $urandom;
                b_wen[k]   = 1'($urandom_range(0, 1));
                b_widx[k]  = 4'($urandom_range(0, 15));
                b_wdata[k] = {$urandom, $urandom};
            end
            for (int j = 0; j < 2; j++) a_ridx[j] = 5'($urandom_range(0, 7));
            for (int j = 0; j < 4; j++) b_ridx[j] = 4'($urandom_range(0, 15));
            a_rsv     = 1'($urandom_range(0, 1));
            a_rsv_idx = 5'($urandom_range(0, 7));
            b_rsv     = 1'($urandom_range(0, 1));
            b_rsv_idx = 4'($urandom_range(0, 15));
            if_a.wr_en   = {a_wen[1], a_wen[0]};
            if_a.wr_idx  = {a_widx[1], a_widx[0]};
            if_a.wr_data = {a_wdata[1], a_wdata[0]};
            if_a.rd_idx  = {a_ridx[1], a_ridx[0]};
            if_a.rsv_en  = a_rsv;
            if_a.rsv_idx = a_rsv_idx;
            if_b.wr_en   = {b_wen[1], b_wen[0]};
            if_b.wr_idx  = {b_widx[1], b_widx[0]};
            if_b.wr_data = {b_wdata[1], b_wdata[0]};
            if_b.rd_idx  = {b_ridx[3], b_ridx[2], b_ridx[1], b_ridx[0]};
            if_b.rsv_en  = b_rsv;
            if_b.rsv_idx = b_rsv_idx;
            #1;
            for (int j = 0; j < 2; j++) begin
                ea_data = ma_regs[a_ridx[j]];
                ea_busy = ma_busy[a_ridx[j]];
                for (int k = 0; k < 2; k++) begin
                    if (a_wen[k] && a_widx[k] == a_ridx[j]) begin
                        ea_data = a_wdata[k];
                        ea_busy = 1'b0;
                    end
                end
                if (a_ridx[j] == 5'd0) begin
                    ea_data = '0;
                    ea_busy = 1'b0;
                end
                check($sformatf("rnd_a_data c%0d p%0d", c, j), 64'(rda(j)), 64'(ea_data));
                check($sformatf("rnd_a_busy c%0d p%0d", c, j), 64'(if_a.rd_busy[j]),
                      64'(ea_busy));
            end
            check($sformatf("rnd_a_idle c%0d", c), 64'(if_a.all_idle), 64'(ma_busy == '0));
            for (int j = 0; j < 4; j++) begin
                check($sformatf("rnd_b_data c%0d p%0d", c, j), rdb(j), mb_regs[b_ridx[j]]);
                check($sformatf("rnd_b_busy c%0d p%0d", c, j), 64'(if_b.rd_busy[j]),
                      64'(mb_busy[b_ridx[j]]));
            end
            check($sformatf("rnd_b_idle c%0d", c), 64'(if_b.all_idle), 64'(mb_busy == '0));
            if (rst) begin
                for (int i = 0; i < 32; i++) ma_regs[i] = '0;
                for (int i = 0; i < 16; i++) mb_regs[i] = '0;
                ma_busy = '0;
                mb_busy = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (a_wen[k]) begin
                        if (a_widx[k] != 5'd0) ma_regs[a_widx[k]] = a_wdata[k];
                        ma_busy[a_widx[k]] = 1'b0;
                    end
                    if (b_wen[k]) begin
                        mb_regs[b_widx[k]] = b_wdata[k];
                        mb_busy[b_widx[k]] = 1'b0;
                    end
                end
                if (a_rsv && a_rsv_idx != 5'd0) ma_busy[a_rsv_idx] = 1'b1;
                if (b_rsv) mb_busy[b_rsv_idx] = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
